mod_counter: RTL and testbench



---
 rtl/mod_counter.sv | 110 +++++++++++
 tb/tb_mod_counter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/mod_counter.sv
// Parametrised up/down modulo counter with wrap/saturate modes, clamped synchronous load and enable prescaler.
// One-cycle registered update; o_tc is combinational from q and up.
module mod_counter #(
  parameter int WIDTH    = 4,
  parameter int MAX_VAL  = 7,
  parameter int LOAD_VAL = 4,
  parameter int PRESCALE = 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_en,
  input  logic             i_up,
  input  logic             i_sat,
  input  logic             i_load,
  input  logic             i_load_sel,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q,
  output logic             o_tc,
  output logic             o_wrap,
  output logic             o_sat_hit
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [WIDTH-1:0] L_MAX  = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] L_LOAD = WIDTH'(LOAD_VAL);
  localparam logic [PW-1:0]    L_PEND = PW'(PRESCALE - 1);

  logic [WIDTH-1:0] r_q;
  logic [PW-1:0]    r_pre;
  logic             r_wrap;
  logic             r_sat_hit;

  logic [WIDTH-1:0] w_q_nxt;
  logic [PW-1:0]    w_pre_nxt;
  logic             w_wrap_nxt;
  logic             w_sat_nxt;
  logic             w_tick;
  logic [WIDTH-1:0] w_ld_raw;
  logic [WIDTH-1:0] w_ld_val;
  logic             w_at_top;
  logic             w_at_bot;

  assign w_tick   = i_en && (r_pre == L_PEND);
  assign w_ld_raw = i_load_sel ? i_d : L_LOAD;
  // External load values above the terminal value are clamped so q stays in range.
  assign w_ld_val = (w_ld_raw > L_MAX) ? L_MAX : w_ld_raw;
  assign w_at_top = (r_q == L_MAX);
  assign w_at_bot = (r_q == '0);

  always_comb begin
    w_q_nxt    = r_q;
    w_pre_nxt  = r_pre;
    w_wrap_nxt = 1'b0;
    w_sat_nxt  = r_sat_hit;
    if (i_load) begin
      w_q_nxt   = w_ld_val;
      w_pre_nxt = '0;
      w_sat_nxt = 1'b0;
    end else if (i_en) begin
      if (w_tick) begin
        w_pre_nxt = '0;
        if (i_up) begin
          if (!w_at_top) begin
            w_q_nxt   = r_q + WIDTH'(1);
            w_sat_nxt = 1'b0;
          end else if (!i_sat) begin
            w_q_nxt    = '0;
            w_wrap_nxt = 1'b1;
            w_sat_nxt  = 1'b0;
          end else begin
            w_sat_nxt = 1'b1;
          end
        end else begin
          if (!w_at_bot) begin
            w_q_nxt   = r_q - WIDTH'(1);
            w_sat_nxt = 1'b0;
          end else if (!i_sat) begin
            w_q_nxt    = L_MAX;
            w_wrap_nxt = 1'b1;
            w_sat_nxt  = 1'b0;
          end else begin
            w_sat_nxt = 1'b1;
          end
        end
      end else begin
        w_pre_nxt = r_pre + PW'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_q       <= '0;
      r_pre     <= '0;
      r_wrap    <= 1'b0;
      r_sat_hit <= 1'b0;
    end else begin
      r_q       <= w_q_nxt;
      r_pre     <= w_pre_nxt;
      r_wrap    <= w_wrap_nxt;
      r_sat_hit <= w_sat_nxt;
    end
  end

  assign o_q       = r_q;
  assign o_wrap    = r_wrap;
  assign o_sat_hit = r_sat_hit;
  assign o_tc      = i_up ? w_at_top : w_at_bot;

endmodule

// File: tb/tb_mod_counter.sv
// Scoreboard bench for mod_counter: three parameterisations driven in lockstep against a reference model.
module tb_mod_counter;

  logic       clk = 1'b0;
  logic       reset, en, up, sat, load, load_sel;
  logic [7:0] d8;

  logic [3:0] q0, q1;
  logic [7:0] q2;
  logic       tc0, tc1, tc2, wr0, wr1, wr2, sh0, sh1, sh2;

  int checks = 0;
  int errors = 0;

  int MX[3] = '{7, 7, 200};
  int PS[3] = '{1, 3, 1};
  int LV[3] = '{4, 4, 4};
  int MK[3] = '{15, 15, 255};

  int mq[3], mpre[3], mwr[3], msh[3];

  typedef struct {
    int k;
    int q;
    int w;
    int s;
  } exp_t;
  exp_t sbq[$];

  always #5 clk = ~clk;

  mod_counter dut0 (
    .i_clk(clk), .i_reset(reset), .i_en(en), .i_up(up), .i_sat(sat),
    .i_load(load), .i_load_sel(load_sel), .i_d(d8[3:0]),
    .o_q(q0), .o_tc(tc0), .o_wrap(wr0), .o_sat_hit(sh0)
  );

  mod_counter #(.PRESCALE(3)) dut1 (
    .i_clk(clk), .i_reset(reset), .i_en(en), .i_up(up), .i_sat(sat),
    .i_load(load), .i_load_sel(load_sel), .i_d(d8[3:0]),
    .o_q(q1), .o_tc(tc1), .o_wrap(wr1), .o_sat_hit(sh1)
  );

  mod_counter #(.WIDTH(8), .MAX_VAL(200), .LOAD_VAL(4), .PRESCALE(1)) dut2 (
    .i_clk(clk), .i_reset(reset), .i_en(en), .i_up(up), .i_sat(sat),
    .i_load(load), .i_load_sel(load_sel), .i_d(d8),
    .o_q(q2), .o_tc(tc2), .o_wrap(wr2), .o_sat_hit(sh2)
  );

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, act, exp);
    end
  endtask

  function automatic int act_q(input int k);
    case (k)
      0: return int'(q0);
      1: return int'(q1);
      default: return int'(q2);
    endcase
  endfunction

  function automatic int act_w(input int k);
    case (k)
      0: return int'(wr0);
      1: return int'(wr1);
      default: return int'(wr2);
    endcase
  endfunction

  function automatic int act_s(input int k);
    case (k)
      0: return int'(sh0);
      1: return int'(sh1);
      default: return int'(sh2);
    endcase
  endfunction

  function automatic int act_tc(input int k);
    case (k)
      0: return int'(tc0);
      1: return int'(tc1);
      default: return int'(tc2);
    endcase
  endfunction

  // Reference behaviour for one clock edge of counter k.
  task automatic model(input int k, input bit r, input bit e, input bit u, input bit s,
                       input bit l, input bit ls, input int dv);
    int v;
    bit tick;
    if (r) begin
      mq[k] = 0; mpre[k] = 0; mwr[k] = 0; msh[k] = 0;
    end else if (l) begin
      v = ls ? (dv & MK[k]) : LV[k];
      mq[k] = (v > MX[k]) ? MX[k] : v;
      mpre[k] = 0; mwr[k] = 0; msh[k] = 0;
    end else begin
      mwr[k] = 0;
      tick = 1'b0;
      if (e) begin
        if (mpre[k] == PS[k] - 1) begin
          mpre[k] = 0;
          tick = 1'b1;
        end else begin
          mpre[k]++;
        end
      end
      if (tick) begin
        if (u && mq[k] < MX[k]) begin
          mq[k]++; msh[k] = 0;
        end else if (!u && mq[k] > 0) begin
          mq[k]--; msh[k] = 0;
        end else if (s) begin
          msh[k] = 1;
        end else begin
          mq[k] = u ? 0 : MX[k];
          mwr[k] = 1; msh[k] = 0;
        end
      end
    end
  endtask

  task automatic cyc(input bit r, input bit e, input bit u, input bit s,
                     input bit l, input bit ls, input int dv);
    exp_t x;
    reset = r; en = e; up = u; sat = s; load = l; load_sel = ls; d8 = 8'(dv);
    for (int k = 0; k < 3; k++) begin
      model(k, r, e, u, s, l, ls, dv);
      x.k = k; x.q = mq[k]; x.w = mwr[k]; x.s = msh[k];
      sbq.push_back(x);
    end
    @(posedge clk);
    #1;
    while (sbq.size() > 0) begin
      x = sbq.pop_front();
      chk($sformatf("q%0d", x.k), act_q(x.k), x.q);
      chk($sformatf("wrap%0d", x.k), act_w(x.k), x.w);
      chk($sformatf("sat_hit%0d", x.k), act_s(x.k), x.s);
      chk($sformatf("tc%0d", x.k), act_tc(x.k), int'(u ? (x.q == MX[x.k]) : (x.q == 0)));
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; up = 1'b1; sat = 1'b0; load = 1'b0; load_sel = 1'b0; d8 = '0;
    @(negedge clk);
    // reset, then free-running up count with wrap
    repeat (2) cyc(1, 0, 1, 0, 0, 0, 0);
    repeat (10) cyc(0, 1, 1, 0, 0, 0, 0);
    // load 2, count down into saturation, then step back up
    cyc(0, 0, 1, 0, 1, 1, 2);
    repeat (4) cyc(0, 1, 0, 1, 0, 0, 0);
    cyc(0, 1, 1, 1, 0, 0, 0);
    // constant load from 6, clamped external load, load coinciding with a tick
    cyc(0, 0, 1, 0, 1, 1, 6);
    cyc(0, 0, 1, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 1, 1, 255);
    cyc(0, 1, 1, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 1, 0, 0);
    // prescaled counting with en dropped mid-prescale
    cyc(1, 0, 1, 0, 0, 0, 0);
    repeat (4) cyc(0, 1, 1, 0, 0, 0, 0);
    repeat (5) cyc(0, 0, 1, 0, 0, 0, 0);
    repeat (7) cyc(0, 1, 1, 0, 0, 0, 0);
    // change direction mid-prescale
    cyc(0, 1, 0, 0, 0, 0, 0);
    repeat (4) cyc(0, 1, 0, 0, 0, 0, 0);
    // down from reset wraps to MAX_VAL, then reset mid-run
    cyc(1, 0, 0, 0, 0, 0, 0);
    repeat (3) cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0);
    repeat (4) cyc(0, 1, 0, 1, 0, 0, 0);
    // randomised traffic
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0), 1'($urandom),
          ($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0), 1'($urandom),
          int'($urandom_range(0, 255)));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
